window_buffer_nxn: RTL and testbench

WINDOW_BUFFER_NXN -- requirements
Module: window_buffer_nxn

---
 rtl/window_buffer_nxn.sv | 105 ++++++++++
 tb/tb_window_buffer_nxn.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_nxn.sv
// rtl/window_buffer_nxn.sv - WIN x WIN sliding pixel window with right/left/down shift and fill tracking
module window_buffer_nxn #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN        = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             shift_enable,
  input  logic [1:0]                       shift_direction,
  input  logic [WIN*DATA_WIDTH-1:0]        buffer_input,
  output logic [WIN*WIN*DATA_WIDTH-1:0]    buffer_output,
  output logic [DATA_WIDTH-1:0]            buffer_center,
  output logic [$clog2(WIN+1)-1:0]         fill_level,
  output logic                             window_valid
);

  localparam int FW = $clog2(WIN+1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIN);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);

  typedef enum logic [1:0] {
    DIR_HOLD  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  logic [DATA_WIDTH-1:0] win_q [WIN][WIN];
  logic [DATA_WIDTH-1:0] win_d [WIN][WIN];
  logic [FW-1:0]         fill_q, fill_d;
  dir_e                  dir_q, dir_d;
  dir_e                  dir_in;

  assign dir_in = dir_e'(shift_direction);

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    dir_d  = dir_q;
    if (clear) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          win_d[r][c] = '0;
      fill_d = '0;
      dir_d  = DIR_HOLD;
    end else if (shift_enable && dir_in != DIR_HOLD) begin
      case (dir_in)
        DIR_RIGHT: begin
          for (int r = 0; r < WIN; r++) begin
            for (int c = WIN-1; c > 0; c--)
              win_d[r][c] = win_q[r][c-1];
            win_d[r][0] = buffer_input[r*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        DIR_LEFT: begin
          for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN-1; c++)
              win_d[r][c] = win_q[r][c+1];
            win_d[r][WIN-1] = buffer_input[r*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        DIR_DOWN: begin
          for (int c = 0; c < WIN; c++) begin
            for (int r = WIN-1; r > 0; r--)
              win_d[r][c] = win_q[r-1][c];
            win_d[0][c] = buffer_input[c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        default: ;
      endcase
      // A change of direction restarts the run, since the old columns/rows no longer line up.
      dir_d = dir_in;
      if (dir_in != dir_q)
        fill_d = FILL_ONE;
      else if (fill_q != FILL_FULL)
        fill_d = fill_q + FILL_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          win_q[r][c] <= '0;
      fill_q <= '0;
      dir_q  <= DIR_HOLD;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      dir_q  <= dir_d;
    end
  end

  for (genvar gr = 0; gr < WIN; gr++) begin : g_row
    for (genvar gc = 0; gc < WIN; gc++) begin : g_col
      assign buffer_output[(gr*WIN+gc)*DATA_WIDTH +: DATA_WIDTH] = win_q[gr][gc];
    end
  end

  assign buffer_center = win_q[WIN/2][WIN/2];
  assign fill_level    = fill_q;
  assign window_valid  = (fill_q == FILL_FULL);

endmodule

// File: tb/tb_window_buffer_nxn.sv
// tb/tb_window_buffer_nxn.sv - scoreboard bench for window_buffer_nxn at (8,3) and (12,5)
module tb_window_buffer_nxn;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        shift_enable;
  logic [1:0]  shift_direction;
  logic [23:0] in3;
  logic [59:0] in5;

  logic [71:0]  out3;
  logic [7:0]   c3;
  logic [1:0]   fill3;
  logic         v3;
  logic [299:0] out5;
  logic [11:0]  c5;
  logic [2:0]   fill5;
  logic         v5;

  window_buffer_nxn #(.DATA_WIDTH(8), .WIN(3)) dut3 (
    .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
    .shift_direction(shift_direction), .buffer_input(in3),
    .buffer_output(out3), .buffer_center(c3), .fill_level(fill3), .window_valid(v3)
  );

  window_buffer_nxn #(.DATA_WIDTH(12), .WIN(5)) dut5 (
    .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
    .shift_direction(shift_direction), .buffer_input(in5),
    .buffer_output(out5), .buffer_center(c5), .fill_level(fill5), .window_valid(v5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [299:0] out;
    int           fill;
    logic [15:0]  center;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 is the WIN=3 instance, index 1 the WIN=5 instance.
  int m_win[2][7][7];
  int m_run[2];
  int m_last[2];

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++)
          m_win[d][r][c] = 0;
      m_run[d]  = 0;
      m_last[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input int w, input int dw, input bit en,
                            input int dir, input bit clr, input int vals[7], output exp_t e);
    int nw[7][7];
    int mask;
    logic [299:0] t;
    mask = (1 << dw) - 1;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        nw[r][c] = m_win[d][r][c];
    if (clr) begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++)
          nw[r][c] = 0;
      m_run[d]  = 0;
      m_last[d] = 0;
    end else if (en && dir != 0) begin
      for (int r = 0; r < w; r++) begin
        for (int c = 0; c < w; c++) begin
          if (dir == 1) begin
            if (c == 0) nw[r][c] = vals[r] & mask;
            else        nw[r][c] = m_win[d][r][c-1];
          end else if (dir == 2) begin
            if (c == w-1) nw[r][c] = vals[r] & mask;
            else          nw[r][c] = m_win[d][r][c+1];
          end else begin
            if (r == 0) nw[r][c] = vals[c] & mask;
            else        nw[r][c] = m_win[d][r-1][c];
          end
        end
      end
      m_run[d]  = (dir == m_last[d]) ? m_run[d] + 1 : 1;
      m_last[d] = dir;
    end
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        m_win[d][r][c] = nw[r][c];
    e.out = '0;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        t = 300'(m_win[d][r][c]);
        e.out = e.out | (t << ((r*w + c)*dw));
      end
    end
    e.fill   = (m_run[d] < w) ? m_run[d] : w;
    e.center = 16'(m_win[d][w/2][w/2]);
  endtask

  task automatic step(input bit en, input logic [1:0] dir, input bit clr, input int vals[7]);
    exp_t e;
    @(negedge clk);
    shift_enable    = en;
    shift_direction = dir;
    clear           = clr;
    for (int i = 0; i < 3; i++) in3[i*8 +: 8]   = vals[i][7:0];
    for (int i = 0; i < 5; i++) in5[i*12 +: 12] = vals[i][11:0];
    model_step(0, 3, 8, en, int'(dir), clr, vals, e);
    q3.push_back(e);
    model_step(1, 5, 12, en, int'(dir), clr, vals, e);
    q5.push_back(e);
    @(posedge clk);
    #2;
    shift_enable    = 1'b0;
    shift_direction = 2'b00;
    clear           = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out3"}, out3, '0);
    chk({tag, "_fill3"}, fill3, '0);
    chk({tag, "_valid3"}, v3, '0);
    chk({tag, "_center3"}, c3, '0);
    chk({tag, "_out5"}, out5, '0);
    chk({tag, "_fill5"}, fill5, '0);
    chk({tag, "_valid5"}, v5, '0);
  endtask

  // Reset pulse placed between clock edges so only the asynchronous path can clear state.
  task automatic async_pulse();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_rst");
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_fill3", fill3, '0);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("sb_out3", out3, e.out);
      chk("sb_fill3", fill3, e.fill);
      chk("sb_valid3", v3, (e.fill == 3));
      chk("sb_center3", c3, e.center);
    end
    if (q5.size() > 0) begin
      e = q5.pop_front();
      chk("sb_out5", out5, e.out);
      chk("sb_fill5", fill5, e.fill);
      chk("sb_valid5", v5, (e.fill == 5));
      chk("sb_center5", c5, e.center);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v[7];
    logic [1:0] rdir;
    bit ren;
    bit rclr;

    rst = 1'b1;
    clear = 1'b0;
    shift_enable = 1'b0;
    shift_direction = 2'b00;
    in3 = '0;
    in5 = '0;
    model_reset();
    #3;
    check_all_zero("reset");
    #9;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) v[i] = 32'hF1;
    repeat (3) step(1'b0, 2'b01, 1'b0, v);
    step(1'b1, 2'b00, 1'b0, v);
    chk("idle_out3", out3, '0);
    chk("idle_fill3", fill3, '0);
    chk("idle_valid3", v3, '0);

    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 7; i++) v[i] = k;
      step(1'b1, 2'b01, 1'b0, v);
      if (k == 3) begin
        chk("right3_out3", out3, {3{8'd1, 8'd2, 8'd3}});
        chk("right3_valid3", v3, 1'b1);
        chk("right3_valid5", v5, 1'b0);
      end
      if (k == 4) chk("right4_valid5", v5, 1'b0);
    end
    chk("right5_out3", out3, {3{8'd3, 8'd4, 8'd5}});
    chk("right5_center3", c3, 8'd4);
    chk("right5_out5", out5, {5{12'd1, 12'd2, 12'd3, 12'd4, 12'd5}});
    chk("right5_center5", c5, 12'h003);
    chk("right5_valid5", v5, 1'b1);

    step(1'b1, 2'b01, 1'b1, v);
    chk("clr_out3", out3, '0);
    chk("clr_fill3", fill3, '0);

    for (int k = 1; k <= 3; k++) begin
      for (int c = 0; c < 7; c++) v[c] = c + 1 + k;
      step(1'b1, 2'b11, 1'b0, v);
    end
    chk("down_out3", out3, {8'd4, 8'd3, 8'd2, 8'd5, 8'd4, 8'd3, 8'd6, 8'd5, 8'd4});
    chk("down_valid3", v3, 1'b1);

    for (int i = 0; i < 7; i++) v[i] = 32'h5A + i;
    step(1'b1, 2'b01, 1'b0, v);
    step(1'b1, 2'b01, 1'b0, v);
    step(1'b1, 2'b10, 1'b0, v);
    chk("dirchg_fill3", fill3, 2'd1);
    chk("dirchg_valid3", v3, 1'b0);
    step(1'b1, 2'b10, 1'b0, v);
    step(1'b1, 2'b10, 1'b0, v);
    chk("dirchg_refill_valid3", v3, 1'b1);

    step(1'b1, 2'b10, 1'b1, v);
    chk("clrshift_out3", out3, '0);
    chk("clrshift_fill3", fill3, '0);

    step(1'b1, 2'b01, 1'b0, v);
    step(1'b1, 2'b01, 1'b0, v);
    async_pulse();
    step(1'b1, 2'b01, 1'b0, v);
    chk("rst_refill_fill3", fill3, 2'd1);

    rdir = 2'b01;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) rdir = 2'($urandom_range(0, 3));
      ren  = ($urandom_range(0, 5) != 0);
      rclr = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 7; i++) v[i] = int'($urandom);
      step(ren, rdir, rclr, v);
      if ($urandom_range(0, 49) == 0) async_pulse();
    end

    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", 300'(q3.size() + q5.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
